// File: rtl/plic_gateway.sv
// plic_gateway: interrupt gateway placed directly upstream of the PLIC.
//
// Each source i (1..NPLICINT-1) is synchronised through two flops, XORed with
// a programmable polarity and then handled either as a level (irq follows the
// conditioned line) or as an edge (a saturating per-source counter of edges
// that the PLIC drains through its completion pulses). irq is a function of
// registered state only, so there is no combinational path from src to irq.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   addr_req, addr_ack   bus request / accept (addr_ack = addr_req & sel)
//   sel                  block select
//   addr[21:0]           byte address in the block window (addr[2:0] ignored)
//   read                 1 = read, 0 = write
//   mask[7:0]            byte-lane write enables
//   wdata[RV-1:0]        write data
//   data_req, data_ack   read data valid / read data consumed
//   rdata[RV-1:0]        registered read data, stable while data_req = 1
//   src[NPLICINT-1:1]    raw asynchronous interrupt sources
//   complete[NPLICINT-1:1] one-cycle PLIC completion pulse per ID
//   irq[NPLICINT-1:1]    gated requests to the PLIC
//
// Register map (64-bit words): 0x000 MODE, 0x008 POL, 0x010 PEND (RO),
// 0x100 + 8*i CNT[i] (write with mask[0] = 1 clears the count).
module plic_gateway #(
  parameter int NPLICINT = 16,
  parameter int CW       = 4,
  parameter int RV       = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  addr_req,
  output logic                  addr_ack,
  input  logic                  sel,
  input  logic [21:0]           addr,
  input  logic                  read,
  input  logic [7:0]            mask,
  input  logic [RV-1:0]         wdata,
  output logic                  data_req,
  input  logic                  data_ack,
  output logic [RV-1:0]         rdata,
  input  logic [NPLICINT-1:1]   src,
  input  logic [NPLICINT-1:1]   complete,
  output logic [NPLICINT-1:1]   irq
);

  localparam int          IW       = $clog2(NPLICINT);
  localparam logic [18:0] CNT_BASE = 19'h20;
  localparam logic [18:0] NWORDS   = 19'(NPLICINT);

  // One step of the saturating edge counter. An edge coinciding with a
  // completion cancels out; a completion with an empty counter is dropped.
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                             input logic inc,
                                             input logic dec);
    logic [CW-1:0] r;
    r = cnt;
    if (inc && !dec) begin
      if (cnt != '1) r = cnt + CW'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) r = cnt - CW'(1);
    end
    return r;
  endfunction

  logic [18:0]         word;
  logic [18:0]         cnt_off;
  logic [IW-1:0]       cnt_idx;
  logic                cnt_hit;
  logic                rd_en;
  logic                wr_en;
  logic                mode_wr;
  logic                pol_wr;

  logic [NPLICINT-1:0] src_ext;
  logic [NPLICINT-1:0] sync_p0;
  logic [NPLICINT-1:0] sync_p1;
  logic [NPLICINT-1:0] hist;
  logic [NPLICINT-1:0] r_lvl;
  logic [NPLICINT-1:0] mode_q;
  logic [NPLICINT-1:0] pol_q;
  logic [NPLICINT-1:0] mode_nx;
  logic [NPLICINT-1:0] pol_nx;
  logic [NPLICINT-1:0] chg;
  logic [NPLICINT-1:0] cond;
  logic [NPLICINT-1:0] cond_nx;
  logic [NPLICINT-1:0] edge_det;
  logic [NPLICINT-1:0] cnt_clr;
  logic [NPLICINT-1:0] irq_ext;
  logic [CW-1:0]       cnt_q [NPLICINT];
  logic [RV-1:0]       rd_nx;

  assign addr_ack = addr_req & sel;
  assign rd_en    = addr_req & sel & read;
  assign wr_en    = addr_req & sel & ~read;

  assign word     = addr[21:3];
  assign cnt_off  = word - CNT_BASE;
  assign cnt_idx  = cnt_off[IW-1:0];
  assign cnt_hit  = (word >= CNT_BASE) && (cnt_off < NWORDS);
  assign mode_wr  = wr_en && (word == 19'h0);
  assign pol_wr   = wr_en && (word == 19'h1);

  // ID 0 is reserved: its source slot is tied low.
  assign src_ext  = {src, 1'b0};

  // Configuration next-state with byte-lane masking; bit 0 is never writable.
  always_comb begin
    mode_nx = mode_q;
    pol_nx  = pol_q;
    for (int b = 1; b < NPLICINT; b++) begin
      if (mode_wr && mask[b/8]) mode_nx[b] = wdata[b];
      if (pol_wr  && mask[b/8]) pol_nx[b]  = wdata[b];
    end
    mode_nx[0] = 1'b0;
    pol_nx[0]  = 1'b0;
  end

  // A mode or polarity change restarts the source: counter and level cleared,
  // edge history loaded with the line as seen under the new polarity so the
  // change itself never looks like an edge.
  assign chg      = (mode_nx ^ mode_q) | (pol_nx ^ pol_q);
  assign cond     = sync_p1 ^ pol_q;
  assign cond_nx  = sync_p1 ^ pol_nx;
  assign edge_det = cond & ~hist & mode_q;

  always_comb begin
    cnt_clr = '0;
    for (int i = 1; i < NPLICINT; i++) begin
      cnt_clr[i] = wr_en && cnt_hit && mask[0] && (cnt_idx == IW'(i));
    end
  end

  always_comb begin
    irq_ext = '0;
    for (int i = 1; i < NPLICINT; i++) begin
      irq_ext[i] = mode_q[i] ? (cnt_q[i] != '0) : r_lvl[i];
    end
  end

  assign irq = irq_ext[NPLICINT-1:1];

  // Read data selection, captured into rdata when the read is accepted.
  always_comb begin
    rd_nx = '0;
    case (word)
      19'h0:   rd_nx[NPLICINT-1:0] = mode_q;
      19'h1:   rd_nx[NPLICINT-1:0] = pol_q;
      19'h2:   rd_nx[NPLICINT-1:0] = irq_ext;
      default: begin
        if (cnt_hit && (cnt_idx != '0)) rd_nx[CW-1:0] = cnt_q[cnt_idx];
      end
    endcase
  end

  // Stage p0/p1: two-flop synchroniser; then edge history, level and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      hist    <= '0;
      r_lvl   <= '0;
      mode_q  <= '0;
      pol_q   <= '0;
      for (int i = 0; i < NPLICINT; i++) cnt_q[i] <= '0;
    end else begin
      sync_p0 <= src_ext;
      sync_p1 <= sync_p0;
      mode_q  <= mode_nx;
      pol_q   <= pol_nx;
      hist    <= cond_nx;
      r_lvl   <= ~mode_nx & cond_nx & ~chg;
      cnt_q[0] <= '0;
      for (int i = 1; i < NPLICINT; i++) begin
        if (chg[i] || cnt_clr[i] || !mode_q[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_step(cnt_q[i], edge_det[i], complete[i]);
        end
      end
    end
  end

  // Read response: a new accept wins over the ack, so back-to-back reads keep
  // data_req high and simply present the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_req <= 1'b0;
      rdata    <= '0;
    end else if (rd_en) begin
      data_req <= 1'b1;
      rdata    <= rd_nx;
    end else if (data_ack) begin
      data_req <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, addr[2:0], wdata, mask, edge_det[0], cnt_clr[0], r_lvl[0]};

endmodule
